// File: rtl/button_sync_pkg.sv
// rtl/button_sync_pkg.sv - shared types and default parameters for the button synchronizer
package button_sync_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_ON   = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 0;

endpackage

// File: rtl/button_synchronizer_sync_chain.sv
// rtl/button_synchronizer_sync_chain.sv - flop chain that brings asynchronous inputs into the clock domain
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                s[i] <= '0;
            end
        end else begin
            s[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                s[i] <= s[i-1];
            end
        end
    end

    assign q = s[STAGES-1];

endmodule

// File: rtl/button_synchronizer.sv
// rtl/button_synchronizer.sv - converts a raw button level into one clean pulse per press
module button_synchronizer
    import button_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic bi,
    output logic bo
);

    logic   bsync;
    logic   bclean;
    state_t state;
    state_t state_nxt;

    sync_chain #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (Clk),
        .rst_n (Rst),
        .d     (bi),
        .q     (bsync)
    );

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign bclean = bsync;
        end else begin : g_debounce
            logic [CNT_W-1:0] cnt;
            logic             level;

            // cnt counts earlier consecutive disagreeing samples; the current one completes the run
            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    cnt   <= '0;
                    level <= 1'b0;
                end else if (bsync != level) begin
                    if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        level <= bsync;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end

            assign bclean = level;
        end
    endgenerate

    always_comb begin
        state_nxt = S_OFF;
        case (state)
            S_OFF:   state_nxt = bclean ? S_ON   : S_OFF;
            S_ON:    state_nxt = bclean ? S_WAIT : S_OFF;
            S_WAIT:  state_nxt = bclean ? S_WAIT : S_OFF;
            default: state_nxt = S_OFF;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    assign bo = (state == S_ON);

endmodule

// File: tb/tb_button_synchronizer.sv
// tb/tb_button_synchronizer.sv - self-checking bench for button_synchronizer, bypass and debounced builds
module tb_button_synchronizer;

    localparam int S = 2;
    localparam int D = 4;

    logic Clk_tb;
    logic rst_n;
    logic bi;
    logic bi_db;
    logic bo;
    logic bo_db;

    button_synchronizer dut (
        .Clk (Clk_tb),
        .Rst (rst_n),
        .bi  (bi),
        .bo  (bo)
    );

    button_synchronizer #(.DEBOUNCE_CYCLES(D)) dut_db (
        .Clk (Clk_tb),
        .Rst (rst_n),
        .bi  (bi_db),
        .bo  (bo_db)
    );

    initial Clk_tb = 1'b0;
    always #100 Clk_tb = ~Clk_tb;

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, ecount);
        end
    endtask

    // Model: sampled-level history; a pulse marks a 0->1 change of the level the FSM sees
    bit hist_a [16];
    bit hist_b [16];
    bit prev_a, prev_b, clean_b;
    bit exp_a, exp_b;

    initial begin
        bit all_diff;
        forever begin
            @(posedge Clk_tb or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 16; i++) begin
                    hist_a[i] = 1'b0;
                    hist_b[i] = 1'b0;
                end
                prev_a = 0; prev_b = 0; clean_b = 0; exp_a = 0; exp_b = 0;
            end else begin
                for (int i = 15; i > 0; i--) begin
                    hist_a[i] = hist_a[i-1];
                    hist_b[i] = hist_b[i-1];
                end
                hist_a[0] = bi;
                hist_b[0] = bi_db;
                exp_a  = hist_a[S] && !prev_a;
                prev_a = hist_a[S];
                exp_b  = clean_b && !prev_b;
                prev_b = clean_b;
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (hist_b[S+j] == clean_b) all_diff = 1'b0;
                end
                if (all_diff) clean_b = !clean_b;
            end
        end
    end

    int  rises_a = 0, rises_b = 0, last_rise_a = 0, last_rise_b = 0;
    bit  last_a = 0, last_b = 0, dbl = 0;

    initial begin
        forever begin
            @(posedge Clk_tb);
            ecount++;
            #50;
            check("bo_model", int'(bo), int'(exp_a));
            check("bo_db_model", int'(bo_db), int'(exp_b));
            if (bo && !last_a) begin rises_a++; last_rise_a = ecount; end
            if (bo_db && !last_b) begin rises_b++; last_rise_b = ecount; end
            if ((bo && last_a) || (bo_db && last_b)) dbl = 1;
            last_a = bo;
            last_b = bo_db;
        end
    end

    task automatic put(input logic a, input logic b, input int n, output int k);
        @(negedge Clk_tb);
        bi = a; bi_db = b;
        k = ecount + 1;
        repeat (n - 1) @(negedge Clk_tb);
    endtask

    initial begin
        int k, k2, t, r0, rb0, rel;
        bit found;
        rst_n = 1'b0; bi = 1'bx; bi_db = 1'b0;
        repeat (2) @(negedge Clk_tb);
        check("reset_bo", int'(bo), 0);
        check("reset_bo_db", int'(bo_db), 0);
        bi = 1'b0;
        rst_n = 1'b1;
        put(0, 0, 4, t);
        check("idle_rises", rises_a, 0);

        // single press of 3 cycles
        r0 = rises_a;
        put(1, 0, 3, k);
        put(0, 0, 6, t);
        check("press_pulses", rises_a - r0, 1);
        check("press_latency", last_rise_a - k, 2);

        // one-cycle press, one-cycle release, one-cycle re-press
        r0 = rises_a;
        put(1, 0, 1, k);
        put(0, 0, 1, t);
        put(1, 0, 1, k2);
        put(0, 0, 6, t);
        check("repress_pulses", rises_a - r0, 2);
        check("repress_latency", last_rise_a - k2, 2);

        // long hold
        r0 = rises_a;
        put(1, 0, 50, k);
        put(0, 0, 6, t);
        check("hold_pulses", rises_a - r0, 1);

        // reset in the middle of a pulse, button still held
        put(1, 0, 1, k);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge Clk_tb);
            #60;
            if (bo) found = 1;
        end
        check("reset_wait_pulse", int'(found), 1);
        rst_n = 1'b0;
        #1;
        check("reset_async_drop", int'(bo), 0);
        @(negedge Clk_tb);
        rst_n = 1'b1;
        rel = ecount;
        r0 = rises_a;
        repeat (8) @(negedge Clk_tb);
        check("post_reset_pulses", rises_a - r0, 1);
        check("post_reset_latency", last_rise_a - rel, 3);
        put(0, 0, 6, t);

        // debounced build: bounces, short press, then stable press
        rb0 = rises_b;
        put(0, 1, 1, t);
        put(0, 0, 1, t);
        put(0, 1, 1, t);
        put(0, 0, 8, t);
        check("bounce_no_pulse", rises_b - rb0, 0);
        put(0, 1, 3, t);
        put(0, 0, 8, t);
        check("short_no_pulse", rises_b - rb0, 0);
        put(0, 1, 8, k);
        check("debounce_pulses", rises_b - rb0, 1);
        check("debounce_latency", last_rise_b - k, 2 + D);
        put(0, 0, 10, t);
        check("debounce_release_pulses", rises_b - rb0, 1);

        check("never_two_cycles", int'(dbl), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
